pe_dbuf: RTL and testbench
==========================

PE_DBUF -- requirements
Module: pe_dbuf

Interface
REQ-001 Parameter DATA_W, default 8, width of data_in/data_out.
REQ-002 Parameter WEIGHT_W, default 8, width of w_in/weight_out.
REQ-003 Parameter SUM_W, default 16, width of sum_in/mac_out; SHALL satisfy SUM_W >= DATA_W+WEIGHT_W.
REQ-004 Parameter SIGNED, default 1; 1 = two's-complement operands, 0 = unsigned.
REQ-005 clk  in  1  single clock, all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 active  in  1  enables MAC update and data forwarding.
REQ-008 data_in  in  DATA_W  activation from west neighbour.
REQ-009 w_in  in  WEIGHT_W  weight from north neighbour (load chain).
REQ-010 weight_wren  in  1  load w_in into shadow weight register.
REQ-011 weight_swap  in  1  copy shadow weight into active weight register.
REQ-012 sum_in  in  SUM_W  partial sum from north neighbour.
REQ-013 acc_mode  in  1  0 = systolic sum-through, 1 = local accumulate.
REQ-014 acc_clr  in  1  restart local accumulation; clears sat_flag.
REQ-015 mac_out  out  SUM_W  registered MAC result.
REQ-016 data_out  out  DATA_W  registered data_in to east neighbour.
REQ-017 weight_out  out  WEIGHT_W  shadow weight register, to south neighbour.
REQ-018 weight_wren_out, weight_swap_out, active_out  out  1 each  registered copies of corresponding inputs.
REQ-019 sat_flag  out  1  sticky saturation indicator.

Function
REQ-020 Every output SHALL be registered; latency input->output is exactly 1 clk cycle.
REQ-021 weight_wren=1 SHALL load shadow <= w_in; shadow and weight_out SHALL hold otherwise, independent of active.
REQ-022 weight_swap=1 SHALL load active weight <= shadow (pre-edge value); with simultaneous weight_wren, active gets old shadow, shadow gets w_in.
REQ-023 weight_wren_out, weight_swap_out, active_out SHALL follow their inputs every cycle regardless of active.
REQ-024 product = data_in * active weight, full DATA_W+WEIGHT_W bits, signed or unsigned per SIGNED, extended to SUM_W+1 bits.
REQ-025 active=1, acc_mode=0: mac_out <= sat(sum_in + product).
REQ-026 active=1, acc_mode=1, acc_clr=0: mac_out <= sat(mac_out + product).
REQ-027 active=1, acc_mode=1, acc_clr=1: mac_out <= sat(product) (new accumulation starts with current product).
REQ-028 active=1: data_out <= data_in; active=0: mac_out and data_out SHALL hold.
REQ-029 sat(): clamp to [-2^(SUM_W-1), 2^(SUM_W-1)-1] if SIGNED else [0, 2^SUM_W-1]; no wrap-around.
REQ-030 sat_flag SHALL set on any clamping cycle and stay set until acc_clr=1 (acc_clr with simultaneous clamp leaves it set).
REQ-031 acc_clr with active=0 SHALL clear sat_flag only; mac_out holds.
REQ-032 Product SHALL use the active weight as registered before the edge; a swap takes effect on the following cycle.

Reset
REQ-033 rst=1 SHALL immediately clear mac_out, data_out, weight_out, shadow, active weight, sat_flag and all *_out strobes to 0.
REQ-034 rst asserted mid-accumulation SHALL discard the accumulation; first active cycle after release behaves per REQ-025..027 from zero state.

Structure
REQ-035 Package pe_pkg SHALL hold default width constants and the saturation bound helper functions.
REQ-036 Sub-module pe_mac_sat SHALL implement the combinational multiply, add and saturate, returning result and clamp flag.

Verification
REQ-037 Defaults, SIGNED=1: wren w_in=3, swap, then data_in=4 sum_in=10 acc_mode=0 -> mac_out=22 one cycle later.
REQ-038 acc_mode=1: acc_clr with data=2 w=5, then 3 cycles data=2 -> mac_out 10,20,30,40.
REQ-039 w=127, data=127, sum_in=0x7F00, acc_mode=0 -> mac_out=0x7FFF, sat_flag=1 until acc_clr.
REQ-040 SIGNED=1, w=-128, data=127, sum_in=0x8000 -> mac_out=0x8000, sat_flag=1.
REQ-041 shadow=7 active=3, simultaneous wren w_in=9 and swap -> next cycle active=7, weight_out=9; product uses 3 on swap cycle.
REQ-042 rst pulse mid-accumulation (mac_out=40) -> all outputs 0 asynchronously; active=0 afterwards -> mac_out holds 0.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared width defaults and saturation-bound helpers for the processing element.
// Bounds are returned as 64-bit values; callers size-cast them to their datapath width.
package pe_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_WEIGHT_W = 8;
  localparam int DEF_SUM_W    = 16;
  localparam int DEF_SIGNED   = 1;

  function automatic longint sat_hi(input int sum_w, input bit sgn);
    if (sgn)
      return (longint'(1) <<< (sum_w - 1)) - longint'(1);
    else
      return (longint'(1) <<< sum_w) - longint'(1);
  endfunction

  function automatic longint sat_lo(input int sum_w, input bit sgn);
    if (sgn)
      return -(longint'(1) <<< (sum_w - 1));
    else
      return longint'(0);
  endfunction

endpackage

// File: rtl/pe_dbuf_if.sv
// Neighbour-facing bus of one systolic PE: west/north inputs, east/south/result outputs.
// The slave modport is the PE's view; master is the driving environment's view.
interface pe_dbuf_if
  import pe_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  parameter int SUM_W    = DEF_SUM_W
) ();

  logic                active;
  logic [DATA_W-1:0]   data_in;
  logic [WEIGHT_W-1:0] w_in;
  logic                weight_wren;
  logic                weight_swap;
  logic [SUM_W-1:0]    sum_in;
  logic                acc_mode;
  logic                acc_clr;

  logic [SUM_W-1:0]    mac_out;
  logic [DATA_W-1:0]   data_out;
  logic [WEIGHT_W-1:0] weight_out;
  logic                weight_wren_out;
  logic                weight_swap_out;
  logic                active_out;
  logic                sat_flag;

  modport master (
    output active, data_in, w_in, weight_wren, weight_swap, sum_in, acc_mode, acc_clr,
    input  mac_out, data_out, weight_out, weight_wren_out, weight_swap_out, active_out,
           sat_flag
  );

  modport slave (
    input  active, data_in, w_in, weight_wren, weight_swap, sum_in, acc_mode, acc_clr,
    output mac_out, data_out, weight_out, weight_wren_out, weight_swap_out, active_out,
           sat_flag
  );

endinterface

// File: rtl/pe_mac_sat.sv
// Combinational multiply-add with clamping to the SUM_W range; no state.
// Sum is formed two bits wider than SUM_W so neither operand extension can overflow.
module pe_mac_sat
  import pe_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  parameter int SUM_W    = DEF_SUM_W,
  parameter int SIGNED   = DEF_SIGNED
) (
  input  logic [DATA_W-1:0]   data_i,
  input  logic [WEIGHT_W-1:0] weight_i,
  input  logic [SUM_W-1:0]    addend_i,
  output logic [SUM_W-1:0]    result_o,
  output logic                clamp_o
);

  localparam int PW = DATA_W + WEIGHT_W;
  localparam int XW = SUM_W + 2;
  localparam logic signed [XW-1:0] HI = XW'(sat_hi(SUM_W, SIGNED != 0));
  localparam logic signed [XW-1:0] LO = XW'(sat_lo(SUM_W, SIGNED != 0));

  logic                 d_s;
  logic                 w_s;
  logic                 a_s;
  logic                 p_s;
  logic [PW-1:0]        d_ext;
  logic [PW-1:0]        w_ext;
  logic [PW-1:0]        prod;
  logic signed [XW-1:0] sum_x;

  assign d_s = (SIGNED != 0) && data_i[DATA_W-1];
  assign w_s = (SIGNED != 0) && weight_i[WEIGHT_W-1];
  assign a_s = (SIGNED != 0) && addend_i[SUM_W-1];

  // Operands pre-extended to the product width, so the low PW bits are exact for both encodings.
  assign d_ext = {{WEIGHT_W{d_s}}, data_i};
  assign w_ext = {{DATA_W{w_s}}, weight_i};
  assign prod  = d_ext * w_ext;
  assign p_s   = (SIGNED != 0) && prod[PW-1];

  assign sum_x = $signed({{2{a_s}}, addend_i}) + $signed({{(XW-PW){p_s}}, prod});

  always_comb begin
    result_o = sum_x[SUM_W-1:0];
    clamp_o  = 1'b0;
    if (sum_x > HI) begin
      result_o = HI[SUM_W-1:0];
      clamp_o  = 1'b1;
    end else if (sum_x < LO) begin
      result_o = LO[SUM_W-1:0];
      clamp_o  = 1'b1;
    end
  end

endmodule

// File: rtl/pe_dbuf.sv
// Systolic PE with double-buffered weights (shadow load chain + swap) and a saturating MAC.
// All outputs registered, one cycle input-to-output; reset clears every register asynchronously.
module pe_dbuf
  import pe_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  parameter int SUM_W    = DEF_SUM_W,
  parameter int SIGNED   = DEF_SIGNED
) (
  input logic         clk,
  input logic         rst,
  pe_dbuf_if.slave    bus
);

  logic [WEIGHT_W-1:0] shadow_q, shadow_d;
  logic [WEIGHT_W-1:0] wact_q,   wact_d;
  logic [SUM_W-1:0]    mac_q,    mac_d;
  logic [DATA_W-1:0]   dout_q,   dout_d;
  logic                sat_q,    sat_d;
  logic                wren_q;
  logic                swap_q;
  logic                act_q;

  logic [SUM_W-1:0]    addend;
  logic [SUM_W-1:0]    mac_res;
  logic                mac_clamp;

  // Accumulate mode adds onto our own result; a clear restarts from the current product alone.
  always_comb begin
    addend = bus.sum_in;
    if (bus.acc_mode)
      addend = bus.acc_clr ? '0 : mac_q;
  end

  pe_mac_sat #(
    .DATA_W   (DATA_W),
    .WEIGHT_W (WEIGHT_W),
    .SUM_W    (SUM_W),
    .SIGNED   (SIGNED)
  ) u_mac (
    .data_i   (bus.data_in),
    .weight_i (wact_q),
    .addend_i (addend),
    .result_o (mac_res),
    .clamp_o  (mac_clamp)
  );

  always_comb begin
    shadow_d = shadow_q;
    wact_d   = wact_q;
    mac_d    = mac_q;
    dout_d   = dout_q;
    sat_d    = sat_q;
    if (bus.weight_wren)
      shadow_d = bus.w_in;
    if (bus.weight_swap)
      wact_d = shadow_q;
    if (bus.active) begin
      mac_d  = mac_res;
      dout_d = bus.data_in;
    end
    // A clamp in the same cycle as a clear wins, so the overflow is never lost.
    if (bus.active && mac_clamp)
      sat_d = 1'b1;
    else if (bus.acc_clr)
      sat_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      wact_q   <= '0;
      mac_q    <= '0;
      dout_q   <= '0;
      sat_q    <= 1'b0;
      wren_q   <= 1'b0;
      swap_q   <= 1'b0;
      act_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      wact_q   <= wact_d;
      mac_q    <= mac_d;
      dout_q   <= dout_d;
      sat_q    <= sat_d;
      wren_q   <= bus.weight_wren;
      swap_q   <= bus.weight_swap;
      act_q    <= bus.active;
    end
  end

  assign bus.mac_out         = mac_q;
  assign bus.data_out        = dout_q;
  assign bus.weight_out      = shadow_q;
  assign bus.weight_wren_out = wren_q;
  assign bus.weight_swap_out = swap_q;
  assign bus.active_out      = act_q;
  assign bus.sat_flag        = sat_q;

endmodule

// File: tb/tb_pe_dbuf.sv
// Directed bench for pe_dbuf: driver queues hand-computed outputs, monitor checks them a cycle later.
module tb_pe_dbuf;

  typedef struct {
    logic [15:0] mac;
    logic [7:0]  dout;
    logic [7:0]  wout;
    logic        sat;
    logic [2:0]  str;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  pe_dbuf_if bus ();

  pe_dbuf dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".mac_out"},    32'(bus.mac_out),    32'(e.mac));
    chk({tag, ".data_out"},   32'(bus.data_out),   32'(e.dout));
    chk({tag, ".weight_out"}, 32'(bus.weight_out), 32'(e.wout));
    chk({tag, ".sat_flag"},   32'(bus.sat_flag),   32'(e.sat));
    chk({tag, ".strobes"},
        32'({bus.weight_wren_out, bus.weight_swap_out, bus.active_out}), 32'(e.str));
  endtask

  task automatic idle();
    bus.active      = 1'b0;
    bus.data_in     = '0;
    bus.w_in        = '0;
    bus.weight_wren = 1'b0;
    bus.weight_swap = 1'b0;
    bus.sum_in      = '0;
    bus.acc_mode    = 1'b0;
    bus.acc_clr     = 1'b0;
  endtask

  // One cycle of stimulus plus the outputs expected right after the following rising edge.
  task automatic drv(input logic act, input logic [7:0] din, input logic [7:0] w,
                     input logic wren, input logic swap, input logic [15:0] sum,
                     input logic mode, input logic clr,
                     input logic [15:0] e_mac, input logic [7:0] e_dout,
                     input logic [7:0] e_wout, input logic e_sat, input logic [2:0] e_str);
    exp_t e;
    @(negedge clk);
    bus.active      = act;
    bus.data_in     = din;
    bus.w_in        = w;
    bus.weight_wren = wren;
    bus.weight_swap = swap;
    bus.sum_in      = sum;
    bus.acc_mode    = mode;
    bus.acc_clr     = clr;
    e.mac  = e_mac;
    e.dout = e_dout;
    e.wout = e_wout;
    e.sat  = e_sat;
    e.str  = e_str;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    int n = 0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        n++;
        chk_all($sformatf("cyc%0d", n), e);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

  initial begin : driver
    exp_t zero;
    zero.mac = '0; zero.dout = '0; zero.wout = '0; zero.sat = 1'b0; zero.str = '0;
    idle();
    #12;
    chk_all("reset", zero);
    @(negedge clk);
    rst = 1'b0;

    // Load 3, swap, then 4*3 + 10
    drv(0, 0,   3, 1, 0, 0,  0, 0,  16'd0,  0, 3, 0, 3'b100);
    drv(0, 0,   0, 0, 1, 0,  0, 0,  16'd0,  0, 3, 0, 3'b010);
    drv(1, 4,   0, 0, 0, 10, 0, 0,  16'd22, 4, 3, 0, 3'b001);
    // Local accumulation with weight 5, data 2
    drv(0, 0,   5, 1, 0, 0,  0, 0,  16'd22, 4, 5, 0, 3'b100);
    drv(0, 0,   0, 0, 1, 0,  0, 0,  16'd22, 4, 5, 0, 3'b010);
    drv(1, 2,   0, 0, 0, 0,  1, 1,  16'd10, 2, 5, 0, 3'b001);
    drv(1, 2,   0, 0, 0, 0,  1, 0,  16'd20, 2, 5, 0, 3'b001);
    drv(1, 2,   0, 0, 0, 0,  1, 0,  16'd30, 2, 5, 0, 3'b001);
    drv(1, 2,   0, 0, 0, 0,  1, 0,  16'd40, 2, 5, 0, 3'b001);

    // Asynchronous reset in the middle of a clock phase
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", zero);
    @(negedge clk);
    idle();
    rst = 1'b0;
    drv(0, 5,   0, 0, 0, 7,  0, 0,  16'd0,  0, 0, 0, 3'b000);

    // Positive saturation, sticky flag, clear while idle
    drv(0, 0, 127, 1, 0, 0,  0, 0,  16'd0,  0, 127, 0, 3'b100);
    drv(0, 0,   0, 0, 1, 0,  0, 0,  16'd0,  0, 127, 0, 3'b010);
    drv(1, 127, 0, 0, 0, 16'h7F00, 0, 0, 16'h7FFF, 127, 127, 1, 3'b001);
    drv(0, 0,   0, 0, 0, 0,  0, 0,  16'h7FFF, 127, 127, 1, 3'b000);
    drv(0, 0,   0, 0, 0, 0,  0, 1,  16'h7FFF, 127, 127, 0, 3'b000);

    // Negative saturation with weight -128
    drv(0, 0, 8'h80, 1, 0, 0, 0, 0, 16'h7FFF, 127, 8'h80, 0, 3'b100);
    drv(0, 0,   0, 0, 1, 0,  0, 0,  16'h7FFF, 127, 8'h80, 0, 3'b010);
    drv(1, 127, 0, 0, 0, 16'h8000, 0, 0, 16'h8000, 127, 8'h80, 1, 3'b001);
    drv(1, 127, 0, 0, 0, 16'h8000, 0, 1, 16'h8000, 127, 8'h80, 1, 3'b001);
    drv(1, 127, 0, 0, 0, 0,  1, 1,  16'hC080, 127, 8'h80, 0, 3'b001);
    drv(1, 127, 0, 0, 0, 0,  1, 0,  16'h8100, 127, 8'h80, 0, 3'b001);
    drv(1, 127, 0, 0, 0, 0,  1, 0,  16'h8000, 127, 8'h80, 1, 3'b001);

    // Shadow 7 / active 3, then simultaneous load 9 and swap
    drv(0, 0,   3, 1, 0, 0,  0, 0,  16'h8000, 127, 3, 1, 3'b100);
    drv(0, 0,   0, 0, 1, 0,  0, 0,  16'h8000, 127, 3, 1, 3'b010);
    drv(0, 0,   7, 1, 0, 0,  0, 0,  16'h8000, 127, 7, 1, 3'b100);
    drv(1, 2,   9, 1, 1, 0,  0, 0,  16'd6,  2, 9, 1, 3'b111);
    drv(1, 2,   0, 0, 0, 0,  0, 0,  16'd14, 2, 9, 1, 3'b001);

    @(negedge clk);
    idle();
    repeat (5) begin
      if (exp_q.size() > 0) @(negedge clk);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
